// File: rtl/mux_tree_pipe.sv
// rtl/mux_tree_pipe.sv - pipelined N:1 WIDTH-bit mux tree with valid tracking, stall/flush and auto-scan select
module mux_tree_pipe #(
    parameter int WIDTH     = 64,
    parameter int N         = 8,
    parameter int REG_EVERY = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    input  logic [N*WIDTH-1:0]     in_data,
    input  logic [$clog2(N)-1:0]   sel,
    input  logic                   scan_en,
    input  logic                   stall,
    input  logic                   flush,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    output logic [$clog2(N)-1:0]   out_sel,
    output logic [$clog2(N)-1:0]   scan_ptr
);

    localparam int SW = $clog2(N);
    localparam int LV = SW;
    localparam int NS = (LV + REG_EVERY - 1) / REG_EVERY;

    logic [WIDTH-1:0] cand_q   [NS][N];
    logic [WIDTH-1:0] cand_d   [NS][N];
    logic [SW-1:0]    sel_q    [NS];
    logic [SW-1:0]    sel_d    [NS];
    logic [NS-1:0]    valid_q;
    logic [NS-1:0]    valid_d;
    logic [SW-1:0]    scan_ptr_q;
    logic [SW-1:0]    scan_ptr_d;

    logic [WIDTH-1:0] src_cand [NS][N];
    logic [SW-1:0]    src_sel  [NS];
    logic [WIDTH-1:0] tmp      [N];
    logic [SW-1:0]    ssel;
    logic [SW-1:0]    esel;

    always_comb begin
        esel       = scan_en ? scan_ptr_q : sel;
        cand_d     = cand_q;
        sel_d      = sel_q;
        valid_d    = valid_q;
        scan_ptr_d = scan_ptr_q;
        src_cand   = '{default: '{default: '0}};
        src_sel    = '{default: '0};
        tmp        = '{default: '0};
        ssel       = '0;

        // Stage s consumes the registered output of stage s-1; stage 0 consumes the raw inputs.
        for (int j = 0; j < N; j++) begin
            src_cand[0][j] = in_data[j*WIDTH +: WIDTH];
        end
        src_sel[0] = esel;
        for (int s = 1; s < NS; s++) begin
            src_cand[s] = cand_q[s-1];
            src_sel[s]  = sel_q[s-1];
        end

        if (flush) begin
            valid_d = '0;
        end else if (!stall) begin
            valid_d[0] = in_valid;
            for (int s = 1; s < NS; s++) begin
                valid_d[s] = valid_q[s-1];
            end

            for (int s = 0; s < NS; s++) begin
                tmp  = src_cand[s];
                ssel = src_sel[s];
                for (int k = 0; k < LV; k++) begin
                    if (k >= s*REG_EVERY && k < (s+1)*REG_EVERY) begin
                        for (int j = 0; j < N/2; j++) begin
                            if (j < (N >> (k+1))) begin
                                tmp[j] = ssel[k] ? tmp[2*j+1] : tmp[2*j];
                            end
                        end
                    end
                end
                // Slots beyond the surviving candidate count are tied off so they reduce to constants.
                for (int j = 0; j < N; j++) begin
                    if (j >= (N >> (((s+1)*REG_EVERY < LV) ? (s+1)*REG_EVERY : LV))) begin
                        tmp[j] = '0;
                    end
                end
                cand_d[s] = tmp;
                sel_d[s]  = ssel;
            end

            if (!scan_en) begin
                scan_ptr_d = '0;
            end else if (in_valid) begin
                scan_ptr_d = scan_ptr_q + SW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cand_q     <= '{default: '{default: '0}};
            sel_q      <= '{default: '0};
            valid_q    <= '0;
            scan_ptr_q <= '0;
        end else begin
            cand_q     <= cand_d;
            sel_q      <= sel_d;
            valid_q    <= valid_d;
            scan_ptr_q <= scan_ptr_d;
        end
    end

    assign out_valid = valid_q[NS-1];
    assign out_data  = cand_q[NS-1][0];
    assign out_sel   = sel_q[NS-1];
    assign scan_ptr  = scan_ptr_q;

endmodule
